// File: rtl/rec2pol_arbiter_if.sv
// Purpose : bundles the two requester channels and the rec2pol_all datapath
//           channel of rec2pol_arbiter into one interface.
// Latency : none, wiring only.
// Backpressure: none here; requesters watch busyN, the datapath is paced by dp_busy.
//
// Signals (arbiter view, modport slave):
//   start0/1, x0/1, y0/1      in   requester start pulse and operands
//   busy0/1, done0/1, err0/1  out  requester status pulses/levels
//   mod0/1, angle0/1          out  requester results, held until the next done
//   dp_start, dp_x, dp_y      out  job launch towards rec2pol_all
//   dp_busy, dp_mod, dp_angle in   rec2pol_all status and results
// Modport master is the opposite side (port logic plus datapath, or a bench).
interface rec2pol_arbiter_if #(
  parameter int W = 32
);
  logic                start0;
  logic signed [W-1:0] x0;
  logic signed [W-1:0] y0;
  logic                busy0;
  logic                done0;
  logic                err0;
  logic signed [W-1:0] mod0;
  logic signed [W-1:0] angle0;

  logic                start1;
  logic signed [W-1:0] x1;
  logic signed [W-1:0] y1;
  logic                busy1;
  logic                done1;
  logic                err1;
  logic signed [W-1:0] mod1;
  logic signed [W-1:0] angle1;

  logic                dp_start;
  logic signed [W-1:0] dp_x;
  logic signed [W-1:0] dp_y;
  logic                dp_busy;
  logic signed [W-1:0] dp_mod;
  logic signed [W-1:0] dp_angle;

  modport slave (
    input  start0, x0, y0, start1, x1, y1,
    input  dp_busy, dp_mod, dp_angle,
    output busy0, done0, err0, mod0, angle0,
    output busy1, done1, err1, mod1, angle1,
    output dp_start, dp_x, dp_y
  );

  modport master (
    output start0, x0, y0, start1, x1, y1,
    output dp_busy, dp_mod, dp_angle,
    input  busy0, done0, err0, mod0, angle0,
    input  busy1, done1, err1, mod1, angle1,
    input  dp_start, dp_x, dp_y
  );
endinterface

// File: rtl/rec2pol_arbiter.sv
// Purpose : shares one rec2pol_all datapath between two requesters, round-robin.
// Latency : startN to doneN is 4 cycles plus the datapath busy time (idle unit).
// Backpressure: a second startN while busyN=1 is dropped; jobs queue one per requester.
//
// Ports:
//   clock, reset_n  master clock, asynchronous active-low reset
//   bus (slave)     requester 0/1 channels and the rec2pol_all channel,
//                   see rec2pol_arbiter_if
// Parameters: W operand/result width, TIMEOUT_CYC watchdog limit.
// Optional feature: define REC2POL_ARB_TIMEOUT_EN to enable the watchdog that
// aborts a job stuck in the datapath and pulses errN; otherwise errN is 0 and
// the unit waits on dp_busy forever.
module rec2pol_arbiter #(
  parameter int W           = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic             clock,
  input logic             reset_n,
  rec2pol_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAITHI = 3'd2,
    WAITLO = 3'd3,
    DONE   = 3'd4
  } state_t;

  // A watchdog limit below 2 cannot count anything useful; nothing is built either way.
  if (TIMEOUT_CYC < 2) begin : g_timeout_cfg_bad
  end

  state_t               state_q, state_d;
  logic [1:0]           pend_q, pend_d;
  logic                 ptr_q, ptr_d;     // requester that wins a tie
  logic                 owner_q, owner_d;
  logic [1:0][W-1:0]    opx_q, opx_d;
  logic [1:0][W-1:0]    opy_q, opy_d;
  logic [1:0][W-1:0]    mod_q, mod_d;
  logic [1:0][W-1:0]    ang_q, ang_d;
  logic [W-1:0]         dp_x_q, dp_x_d;
  logic [W-1:0]         dp_y_q, dp_y_d;
  logic                 dp_start_q, dp_start_d;
  logic [1:0]           done_q, done_d;
  logic [1:0]           err_q, err_d;

  logic [1:0]           start_in;
  logic [1:0][W-1:0]    x_in;
  logic [1:0][W-1:0]    y_in;
  logic                 grant;

  assign start_in = {bus.start1, bus.start0};
  assign x_in     = {bus.x1, bus.x0};
  assign y_in     = {bus.y1, bus.y0};

  // Only one pending: take it. Both pending: the one not served last.
  assign grant = (pend_q == 2'b11) ? ptr_q : pend_q[1];

`ifdef REC2POL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired;

  assign expired = (cnt_q == CNT_LAST);
`endif

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    opx_d      = opx_q;
    opy_d      = opy_q;
    mod_d      = mod_q;
    ang_d      = ang_q;
    dp_x_d     = dp_x_q;
    dp_y_d     = dp_y_q;
    dp_start_d = 1'b0;
    done_d     = 2'b00;
    err_d      = 2'b00;
`ifdef REC2POL_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    // Accept a new job only from an idle requester; a busy one keeps its operands.
    // The owner's pend is always set here, so this never collides with the clear below.
    for (int i = 0; i < 2; i++) begin
      if (start_in[i] && !pend_q[i]) begin
        pend_d[i] = 1'b1;
        opx_d[i]  = x_in[i];
        opy_d[i]  = y_in[i];
      end
    end

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          owner_d    = grant;
          ptr_d      = ~grant;
          dp_x_d     = opx_q[grant];
          dp_y_d     = opy_q[grant];
          dp_start_d = 1'b1;   // registered, so high exactly during LAUNCH
          state_d    = LAUNCH;
`ifdef REC2POL_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end

      LAUNCH: begin
        state_d = WAITHI;
      end

      WAITHI: begin
`ifdef REC2POL_ARB_TIMEOUT_EN
        if (expired) begin
          err_d[owner_q]  = 1'b1;
          pend_d[owner_q] = 1'b0;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (bus.dp_busy) state_d = WAITLO;
        end
`else
        if (bus.dp_busy) state_d = WAITLO;
`endif
      end

      WAITLO: begin
`ifdef REC2POL_ARB_TIMEOUT_EN
        // A completion seen on the last counted cycle still wins over the abort.
        if (!bus.dp_busy) begin
          state_d = DONE;
        end else if (expired) begin
          err_d[owner_q]  = 1'b1;
          pend_d[owner_q] = 1'b0;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        if (!bus.dp_busy) state_d = DONE;
`endif
      end

      DONE: begin
        mod_d[owner_q]  = bus.dp_mod;
        ang_d[owner_q]  = bus.dp_angle;
        done_d[owner_q] = 1'b1;
        pend_d[owner_q] = 1'b0;
        state_d         = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pend_q     <= 2'b00;
      ptr_q      <= 1'b0;
      owner_q    <= 1'b0;
      opx_q      <= '0;
      opy_q      <= '0;
      mod_q      <= '0;
      ang_q      <= '0;
      dp_x_q     <= '0;
      dp_y_q     <= '0;
      dp_start_q <= 1'b0;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      opx_q      <= opx_d;
      opy_q      <= opy_d;
      mod_q      <= mod_d;
      ang_q      <= ang_d;
      dp_x_q     <= dp_x_d;
      dp_y_q     <= dp_y_d;
      dp_start_q <= dp_start_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef REC2POL_ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.err0 = err_q[0];
  assign bus.err1 = err_q[1];
`else
  assign bus.err0 = 1'b0;
  assign bus.err1 = 1'b0;
`endif

  // busyN is the pending flag itself, so it drops on the same edge that raises doneN/errN.
  assign bus.busy0    = pend_q[0];
  assign bus.busy1    = pend_q[1];
  assign bus.done0    = done_q[0];
  assign bus.done1    = done_q[1];
  assign bus.mod0     = mod_q[0];
  assign bus.mod1     = mod_q[1];
  assign bus.angle0   = ang_q[0];
  assign bus.angle1   = ang_q[1];
  assign bus.dp_start = dp_start_q;
  assign bus.dp_x     = dp_x_q;
  assign bus.dp_y     = dp_y_q;

endmodule

// File: tb/tb_rec2pol_arbiter.sv
// Purpose : directed self-checking bench for rec2pol_arbiter with a behavioural
//           rec2pol_all model (busy for 20 cycles starting 1 cycle after dp_start,
//           mod = integer sqrt(x*x+y*y), angle = x - y).
// Define REC2POL_ARB_TIMEOUT_EN to also build the watchdog scenario (limit 64).
module tb_rec2pol_arbiter;
  localparam int W = 32;
`ifdef REC2POL_ARB_TIMEOUT_EN
  localparam int TO = 64;
`else
  localparam int TO = 1024;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic hang    = 1'b0;

  always #5 clock = ~clock;

  rec2pol_arbiter_if #(.W(W)) bus();

  rec2pol_arbiter #(.W(W), .TIMEOUT_CYC(TO)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- rec2pol_all model ----------------
  function automatic longint isqrt(input longint v);
    longint r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  int mcnt;
  assign bus.dp_busy = (mcnt != 0) || hang;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcnt <= 0;
    end else if (bus.dp_start) begin
      mcnt         <= 20;
      bus.dp_mod   <= W'(isqrt(longint'(bus.dp_x) * longint'(bus.dp_x) +
                               longint'(bus.dp_y) * longint'(bus.dp_y)));
      bus.dp_angle <= bus.dp_x - bus.dp_y;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end

  // ---------------- monitor ----------------
  int nstart = 0, ndone0 = 0, ndone1 = 0, nerr0 = 0, nerr1 = 0;
  logic [W-1:0] grant_q[$];
  int done_order[$];

  always @(negedge clock) begin
    if (bus.dp_start) begin
      nstart++;
      grant_q.push_back(bus.dp_x);
    end
    if (bus.done0) begin ndone0++; done_order.push_back(0); end
    if (bus.done1) begin ndone1++; done_order.push_back(1); end
    if (bus.err0) nerr0++;
    if (bus.err1) nerr1++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.start0 = 1'b0; bus.x0 = '0; bus.y0 = '0;
    bus.start1 = 1'b0; bus.x1 = '0; bus.y1 = '0;
    hang       = 1'b0;
    reset_n    = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic pulse(input logic s0, input logic signed [W-1:0] ax0, input logic signed [W-1:0] ay0,
                       input logic s1, input logic signed [W-1:0] ax1, input logic signed [W-1:0] ay1);
    bus.start0 = s0; bus.x0 = ax0; bus.y0 = ay0;
    bus.start1 = s1; bus.x1 = ax1; bus.y1 = ay1;
    tick();
    bus.start0 = 1'b0;
    bus.start1 = 1'b0;
  endtask

  // which: 0 done0, 1 done1, 2 err0. n = ticks waited until the pulse is seen.
  task automatic wait_for(input int which, input int limit, input string tag, output int n);
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      tick();
      n++;
      case (which)
        0:       seen = bus.done0;
        1:       seen = bus.done1;
        default: seen = bus.err0;
      endcase
    end
    check(tag, seen, 1'b1);
  endtask

  int n, s0, d0, d1;

  initial begin
    bus.start0 = 1'b0; bus.x0 = '0; bus.y0 = '0;
    bus.start1 = 1'b0; bus.x1 = '0; bus.y1 = '0;
    #2;
    // Reset state, sampled while reset is still asserted.
    check("rst_busy0", bus.busy0, 0);
    check("rst_done0", bus.done0, 0);
    check("rst_dp_start", bus.dp_start, 0);
    check("rst_dp_x", bus.dp_x, 0);
    check("rst_mod1", bus.mod1, 0);
    check("rst_err0", bus.err0, 0);
    do_reset();

    // 1. single job from requester 0
    s0 = nstart;
    pulse(1, 3, 4, 0, 0, 0);
    check("t1_busy0_up", bus.busy0, 1);
    check("t1_busy1_idle", bus.busy1, 0);
    wait_for(0, 100, "t1_done0_seen", n);
    check("t1_latency", n, 24);
    check("t1_mod0", bus.mod0, 5);
    check("t1_angle0", bus.angle0, -1);
    check("t1_busy0_falls", bus.busy0, 0);
    check("t1_busy1", bus.busy1, 0);
    check("t1_dp_y_hold", bus.dp_y, 4);
    check("t1_nstart", nstart - s0, 1);
    check("t1_dp_x", grant_q[$], 3);

    // 2. simultaneous requests, ptr=0 after reset
    do_reset();
    s0 = nstart;
    done_order.delete();
    pulse(1, 6, 8, 1, 5, 12);
    wait_for(1, 200, "t2_done1_seen", n);
    check("t2_back_to_back", n, 48);
    check("t2_nstart", nstart - s0, 2);
    check("t2_first", done_order[0], 0);
    check("t2_second", done_order[1], 1);
    check("t2_mod0", bus.mod0, 10);
    check("t2_mod1", bus.mod1, 13);
    check("t2_angle1", bus.angle1, -7);

    // 3. ten simultaneous pairs: strict 0,1,0,1 alternation
    do_reset();
    grant_q.delete();
    for (int i = 0; i < 10; i++) begin
      pulse(1, 32'h100 + i, 0, 1, 32'h200 + i, 0);
      wait_for(1, 200, "t3_pair_done", n);
    end
    check("t3_ngrants", grant_q.size(), 20);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3_grant%0d_req0", 2 * i), grant_q[2 * i], 32'h100 + i);
      check($sformatf("t3_grant%0d_req1", 2 * i + 1), grant_q[2 * i + 1], 32'h200 + i);
    end
    check("t3_mod0", bus.mod0, 32'h109);
    check("t3_mod1", bus.mod1, 32'h209);

    // 4. restart while busy is ignored
    do_reset();
    s0 = nstart;
    d0 = ndone0;
    pulse(1, 8, 15, 0, 0, 0);
    tick();
    check("t4_busy0", bus.busy0, 1);
    pulse(1, 99, 99, 0, 0, 0);
    wait_for(0, 100, "t4_done0_seen", n);
    check("t4_latency", n, 22);
    check("t4_mod0", bus.mod0, 17);
    check("t4_angle0", bus.angle0, -7);
    check("t4_dp_x", grant_q[$], 8);
    repeat (40) tick();
    check("t4_one_done", ndone0 - d0, 1);
    check("t4_one_start", nstart - s0, 1);

    // 5. reset during WAITLO (mod0 still holds 17 from above)
    pulse(1, 3, 4, 0, 0, 0);
    repeat (9) tick();
    check("t5_dp_busy", bus.dp_busy, 1);
    check("t5_busy0_pre", bus.busy0, 1);
    d0 = ndone0;
    reset_n = 1'b0;
    #1;
    check("t5_busy0", bus.busy0, 0);
    check("t5_mod0", bus.mod0, 0);
    check("t5_angle0", bus.angle0, 0);
    check("t5_dp_x", bus.dp_x, 0);
    check("t5_dp_start", bus.dp_start, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    check("t5_no_done", ndone0 - d0, 0);
    pulse(1, 6, 8, 0, 0, 0);
    wait_for(0, 100, "t5_fresh_done", n);
    check("t5_fresh_latency", n, 24);
    check("t5_fresh_mod0", bus.mod0, 10);

`ifdef REC2POL_ARB_TIMEOUT_EN
    // 6. watchdog abort, then the queued requester is served
    do_reset();
    pulse(1, 3, 4, 0, 0, 0);
    wait_for(0, 100, "t6_pre_done", n);
    d0   = ndone0;
    d1   = nerr1;
    hang = 1'b1;
    pulse(1, 6, 8, 0, 0, 0);
    pulse(0, 0, 0, 1, 5, 12);
    wait_for(2, 300, "t6_err0_seen", n);
    check("t6_err_latency", n, 65);
    check("t6_busy0", bus.busy0, 0);
    check("t6_busy1", bus.busy1, 1);
    check("t6_mod0_kept", bus.mod0, 5);
    check("t6_angle0_kept", bus.angle0, -1);
    check("t6_no_done0", ndone0 - d0, 0);
    hang = 1'b0;
    wait_for(1, 200, "t6_done1_seen", n);
    check("t6_mod1", bus.mod1, 13);
    check("t6_no_err1", nerr1 - d1, 0);
`else
    check("no_err0_pulses", nerr0, 0);
    check("no_err1_pulses", nerr1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
